// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data responder with programmable wait cycles over a word array.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  dmem_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        miss_o,
  output logic        arrival_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      count;
  logic            we_q;
  logic [2:0]      type_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            access_edge;
  logic            illegal;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_val;
  logic [3:0]      be;
  logic [31:0]     wbus;

  // Upper address bits only alias the array, so they are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:AW+2];

  assign idx         = addr_q[AW+1:2];
  assign lane        = addr_q[1:0];
  assign access_edge = (state == WAIT) && (count == 4'd0);
  assign word        = mem[idx];
  assign byte_v      = word[{lane, 3'b000} +: 8];
  assign half_v      = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    illegal = 1'b0;
    case (type_q)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = we_q;
      default:                illegal = 1'b1;
    endcase
    if (type_q[1:0] == 2'b01 && lane[0])
      illegal = 1'b1;
    if (type_q[1:0] == 2'b10 && lane != 2'b00)
      illegal = 1'b1;
  end

  always_comb begin
    load_val = '0;
    case (type_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    be   = 4'b0000;
    wbus = wdata_q;
    case (type_q[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wbus = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wbus = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array is not reset; reset forces IDLE, which already blocks the write.
  always_ff @(posedge clk) begin
    if (access_edge && we_q && !illegal) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wbus[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    miss_o    = 1'b0;
    arrival_o = 1'b0;
    case (state)
      IDLE: begin
        miss_o = req_i;
        if (req_i)
          state_nxt = WAIT;
      end
      WAIT: begin
        miss_o = 1'b1;
        if (count == 4'd0)
          state_nxt = DONE;
      end
      DONE: begin
        arrival_o = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_i) begin
        we_q    <= we_i;
        type_q  <= dmem_type_i;
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
        count   <= CNT_INIT;
      end else if (state == WAIT) begin
        if (count != 4'd0)
          count <= count - 4'd1;
        else begin
          rdata_q <= (we_q || illegal) ? 32'd0 : load_val;
          err_q   <= illegal;
        end
      end
    end
  end

  assign rdata_o = arrival_o ? rdata_q : 32'd0;
  assign err_o   = arrival_o & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Randomized and directed bench for dmem_responder against a word-array model.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic        we_i;
  logic [2:0]  dmem_type_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        miss_o;
  logic        arrival_o;
  logic [31:0] rdata_o;
  logic        err_o;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
    .dmem_type_i(dmem_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .miss_o(miss_o), .arrival_o(arrival_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: decides legality, applies stores and forms load results from the access rules.
  task automatic model(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output bit rd_known);
    int          i;
    int          off;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    i   = int'(addr[11:2]);
    off = int'(addr[1:0]);
    if (we) err = !(ty == 3'd0 || ty == 3'd1 || ty == 3'd2);
    else    err = (ty == 3'd3 || ty == 3'd6 || ty == 3'd7);
    if ((ty == 3'd1 || ty == 3'd5) && (off % 2 != 0)) err = 1'b1;
    if (ty == 3'd2 && off != 0) err = 1'b1;
    rd       = 32'd0;
    rd_known = 1'b1;
    if (err) return;
    w = ref_mem[i];
    if (we) begin
      if (ty == 3'd0) w[8*off +: 8] = wd[7:0];
      else if (ty == 3'd1) w[16*(off/2) +: 16] = wd[15:0];
      else begin
        w        = wd;
        known[i] = 1'b1;
      end
      ref_mem[i] = w;
    end else begin
      rd_known = known[i];
      b = 8'(w >> (8*off));
      h = 16'(w >> (16*(off/2)));
      case (ty)
        3'd0:    rd = {{24{b[7]}}, b};
        3'd4:    rd = {24'd0, b};
        3'd1:    rd = {{16{h[15]}}, h};
        3'd5:    rd = {16'd0, h};
        default: rd = w;
      endcase
    end
  endtask

  // Entered and left at posedge+1; the request stays up until arrival is observed.
  task automatic access(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, input bit back2back,
                        output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          rd_known;
    int          arr_cnt;
    int          miss_cnt;
    int          arr_at;
    model(we, ty, addr, wd, exp_rd, exp_err, rd_known);
    req_i = 1'b1; we_i = we; dmem_type_i = ty; addr_i = addr; wdata_i = wd;
    arr_cnt = 0; miss_cnt = 0; arr_at = -1; rd = 32'd0; err = 1'b0;
    for (int c = 0; c < LAT + 8 && arr_cnt == 0; c++) begin
      @(negedge clk);
      if (miss_o) miss_cnt++;
      if (arrival_o) begin
        arr_cnt++;
        arr_at = c;
        rd     = rdata_o;
        err    = err_o;
      end
      @(posedge clk); #1;
      if (arr_cnt == 0) begin
        we_i = 1'($urandom); dmem_type_i = 3'($urandom);
        addr_i = $urandom; wdata_i = $urandom;
      end
    end
    check("arrival_seen", arr_cnt, 1);
    check("arrival_cycle", arr_at, LAT + 1);
    check("miss_cycles", miss_cnt, LAT + 1);
    check("err", {31'd0, err}, {31'd0, exp_err});
    if (rd_known) check("rdata", rd, exp_rd);
    if (!back2back) begin
      req_i = 1'b0;
      @(negedge clk);
      check("idle_after_done", {30'd0, arrival_o, miss_o}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'd0;
      known[i]   = 1'b0;
    end
    reset = 1'b1; req_i = 1'b0; we_i = 1'b0; dmem_type_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss", {31'd0, miss_o}, 32'd0);
    check("rst_arrival", {31'd0, arrival_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, rd, er);
    access(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, rd, er);
    check("lw_100", rd, 32'hDEADBEEF);

    access(1'b1, 3'd2, 32'h200, 32'h80F17F82, 1'b0, rd, er);
    access(1'b0, 3'd0, 32'h200, 32'h0, 1'b0, rd, er);
    check("lb_200", rd, 32'hFFFFFF82);
    access(1'b0, 3'd4, 32'h200, 32'h0, 1'b0, rd, er);
    check("lbu_200", rd, 32'h00000082);
    access(1'b0, 3'd0, 32'h201, 32'h0, 1'b0, rd, er);
    check("lb_201", rd, 32'h0000007F);
    access(1'b0, 3'd1, 32'h202, 32'h0, 1'b0, rd, er);
    check("lh_202", rd, 32'hFFFF80F1);
    access(1'b0, 3'd5, 32'h202, 32'h0, 1'b0, rd, er);
    check("lhu_202", rd, 32'h000080F1);

    access(1'b1, 3'd2, 32'h300, 32'h11223344, 1'b0, rd, er);
    access(1'b1, 3'd0, 32'h301, 32'h000000AA, 1'b0, rd, er);
    access(1'b0, 3'd2, 32'h300, 32'h0, 1'b0, rd, er);
    check("sb_301", rd, 32'h1122AA44);
    access(1'b1, 3'd1, 32'h302, 32'h00005566, 1'b0, rd, er);
    access(1'b0, 3'd2, 32'h300, 32'h0, 1'b0, rd, er);
    check("sh_302", rd, 32'h5566AA44);

    access(1'b0, 3'd2, 32'h102, 32'h0, 1'b0, rd, er);
    check("lw_102_err", {31'd0, er}, 32'd1);
    check("lw_102_rdata", rd, 32'd0);
    access(1'b1, 3'd1, 32'h103, 32'h0000FFFF, 1'b0, rd, er);
    check("sh_103_err", {31'd0, er}, 32'd1);
    access(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, rd, er);
    check("sh_103_unchanged", rd, 32'hDEADBEEF);

    // Back-to-back: each new request is presented the cycle after DONE.
    access(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 1'b1, rd, er);
    for (int i = 0; i < 16; i++)
      access(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b1, rd, er);
    access(1'b1, 3'd2, 32'h1000, 32'hA5A5_0F0F, 1'b1, rd, er);
    access(1'b0, 3'd2, 32'h0, 32'h0, 1'b0, rd, er);
    check("wrap_1000", rd, 32'hA5A5_0F0F);

    // Reset one cycle into WAIT drops the pending store.
    req_i = 1'b1; we_i = 1'b1; dmem_type_i = 3'd2; addr_i = 32'h40; wdata_i = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; req_i = 1'b0;
    #1;
    check("midrst_miss", {31'd0, miss_o}, 32'd0);
    check("midrst_arrival", {31'd0, arrival_o}, 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    check("midrst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, rd, er);
    check("midrst_lw_40", rd, 32'hCAFEF00D);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom % 4);
      access(1'($urandom), 3'($urandom), a, $urandom, 1'($urandom), rd, er);
    end
    req_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM stage data port. It is the far end of the core's load/store interface.
- Accepts one load/store request at a time, holds it for a programmable number of wait cycles, then completes it.
- Drives the m_cmiss / m_arrival pair consumed by the hazard unit, plus the read data for write-back.
- Backed by an internal word array, so it replaces the zero-latency data memory in simulation and bring-up.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 3, wait cycles from accept to completion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  1  request valid; held high by the stalled core until arrival_o.
- we_i  input  1  1 = store, 0 = load.
- dmem_type_i  input  3  access type, RISC-V funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data; the low bits are used for byte/half stores.
- miss_o  output  1  stall request, goes to hazard m_cmiss.
- arrival_o  output  1  one-cycle completion pulse, goes to hazard m_arrival.
- rdata_o  output  32  load result, sign/zero extended; valid only while arrival_o=1.
- err_o  output  1  misaligned access or illegal type; valid only while arrival_o=1.

Behaviour:
- Reset: state=IDLE, counter=0, miss_o=0, arrival_o=0, rdata_o=0, err_o=0. Array contents are not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - miss_o = req_i, combinational, so the pipeline stalls in the request cycle.
  - On the edge with req_i=1: latch we/type/addr/wdata, counter<=LATENCY-1, go to WAIT.
- WAIT:
  - miss_o=1.
  - If counter!=0, decrement.
  - At counter==0 go to DONE. The array access happens on this edge: read captured into the rdata register, or write performed.
- DONE:
  - arrival_o=1, miss_o=0, rdata_o/err_o driven.
  - req_i is ignored in this cycle, because it still carries the completing request.
  - Go to IDLE unconditionally.
- Accept-to-arrival latency: arrival_o is high in cycle LATENCY+1 after the accept edge. A new request can be accepted in the cycle after DONE.
- Total occupancy: LATENCY+2 cycles per access. Back-to-back requests give no overlap.
- Indexing: word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Loads:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 returns the full word.
- Stores:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lane addr[1] with wdata[15:0].
  - Word writes all 4 lanes. Other lanes are unchanged.
  - Store rdata_o=0.
- Errors:
  - Half with addr[0]=1, word with addr[1:0]!=0, any store type other than 000/001/010, and load types 011/110/111.
  - On error: no array write, rdata_o=0, err_o=1 with arrival_o. Timing is unchanged.
- WAIT/DONE ignore changes on the request inputs, since latched values are used.
- Reset asserted mid-access: immediate return to IDLE, outputs to 0, any pending store is dropped. A store whose write edge has already occurred remains written.
- req_i with unknown/stale fields in IDLE is the core's responsibility. The responder accepts whatever is present on the accept edge.

Test Plan:
- Word store then load, LATENCY=3:
  - SW 0xDEADBEEF to 0x100: miss_o high for 4 cycles, then arrival_o for 1 cycle.
  - LW 0x100: rdata_o=0xDEADBEEF, err_o=0.
- Byte/half extension on word 0x80F1_7F82 at 0x200:
  - LB 0x200 -> 0xFFFFFF82; LBU 0x200 -> 0x00000082.
  - LB 0x201 -> 0x0000007F.
  - LH 0x202 -> 0xFFFF80F1; LHU 0x202 -> 0x000080F1.
- Partial store:
  - SB 0xAA at 0x301 over 0x11223344 -> LW 0x300 returns 0x1122AA44.
  - SH 0x5566 at 0x302 -> LW returns 0x5566AA44.
- Misaligned:
  - LW 0x102 -> err_o=1, rdata_o=0 on arrival.
  - SH 0x103 -> err_o=1 and the memory word is unchanged.
- Handshake:
  - req_i held high through DONE with no re-accept; arrival_o asserts exactly once.
  - Second request presented the cycle after DONE is accepted, with miss_o high in that same cycle.
  - Wrap check, DEPTH=1024: SW to 0x1000 aliases word 0.
- Reset mid-WAIT:
  - Assert reset 1 cycle after accepting SW 0x12345678 to 0x40: outputs go to 0 immediately, state=IDLE.
  - Subsequent LW 0x40 returns the prior contents.
